// File: rtl/ecc_telemetry_collector.sv
// ecc_telemetry_collector
//
// Collects the ECC engine's per-read telemetry and turns every qualified
// error into a timestamped record {type, syndrome, tstamp}. Records queue in
// a small FIFO that the PredictRAM predictor drains. The block also keeps
// saturating lifetime counters, a sticky DBE alarm, a sticky record-drop
// flag and a windowed SBE-storm detector.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ml_valid            telemetry qualifier (ECC engine rdata_valid)
//   ml_syndrome         syndrome of the current read
//   ml_err_sbe/_dbe     single-bit (corrected) / double-bit error flags
//   ml_err_in_parity    the SBE sits in the check bits
//   clr_counts          sync clear of counters, alert_dbe, rec_overflow
//   rec_valid/rec_ready record handshake toward the predictor
//   rec_type            01 data SBE, 10 parity SBE, 11 DBE
//   rec_syndrome        syndrome of the head record
//   rec_tstamp          timestamp of the head record
//   sbe/par/dbe_count   saturating lifetime counters
//   alert_dbe           sticky DBE alarm
//   alert_storm         SBE count in the current window reached SBE_THRESH
//   rec_overflow        sticky: a record was dropped on a full FIFO
//
// Handshake: the head record transfers on any clock edge where
// rec_valid=1 and rec_ready=1. While rec_valid=1 and rec_ready=0 the rec_*
// fields hold stable. rec_valid never depends combinationally on the
// telemetry inputs, so a new record is always visible one cycle after the
// event, even when the FIFO was empty and rec_ready was high.

module ecc_telemetry_collector #(
  parameter int ECC_WIDTH     = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int TS_WIDTH      = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SBE_THRESH    = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ml_valid,
  input  logic [ECC_WIDTH-1:0] ml_syndrome,
  input  logic                 ml_err_sbe,
  input  logic                 ml_err_dbe,
  input  logic                 ml_err_in_parity,
  input  logic                 clr_counts,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [1:0]           rec_type,
  output logic [ECC_WIDTH-1:0] rec_syndrome,
  output logic [TS_WIDTH-1:0]  rec_tstamp,
  output logic [CNT_WIDTH-1:0] sbe_count,
  output logic [CNT_WIDTH-1:0] par_count,
  output logic [CNT_WIDTH-1:0] dbe_count,
  output logic                 alert_dbe,
  output logic                 alert_storm,
  output logic                 rec_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int WSB_W = $clog2(SBE_THRESH + 1);
  localparam int REC_W = 2 + ECC_WIDTH + TS_WIDTH;

  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [WSB_W-1:0] WSB_THRESH = WSB_W'(SBE_THRESH);

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_PAR  = 2'b10;
  localparam logic [1:0] TYPE_DBE  = 2'b11;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // ---------------- event classification ----------------
  logic [1:0] w_type;
  logic       w_evt;
  logic       w_is_sbe;

  // DBE dominates; in_parity alone (without sbe) is not an event.
  always_comb begin
    w_type = TYPE_NONE;
    if (ml_valid) begin
      if (ml_err_dbe)                          w_type = TYPE_DBE;
      else if (ml_err_sbe && ml_err_in_parity) w_type = TYPE_PAR;
      else if (ml_err_sbe)                     w_type = TYPE_DATA;
    end
  end

  assign w_evt    = (w_type != TYPE_NONE);
  assign w_is_sbe = (w_type == TYPE_DATA) || (w_type == TYPE_PAR);

  // ---------------- timestamp and storm window ----------------
  logic [TS_WIDTH-1:0] r_tstamp;
  logic [WIN_W-1:0]    r_win_timer;
  logic [WSB_W-1:0]    r_win_sbe;
  logic [WSB_W-1:0]    w_win_sbe_nxt;
  logic                w_win_last;
  logic                r_alert_storm;

  assign w_win_last = (r_win_timer == WIN_LAST);

  // An SBE in the last cycle of a window is the first SBE of the next one.
  always_comb begin
    w_win_sbe_nxt = r_win_sbe;
    if (w_win_last)
      w_win_sbe_nxt = w_is_sbe ? WSB_W'(1) : '0;
    else if (w_is_sbe && (r_win_sbe != WSB_THRESH))
      w_win_sbe_nxt = r_win_sbe + WSB_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tstamp      <= '0;
      r_win_timer   <= '0;
      r_win_sbe     <= '0;
      r_alert_storm <= 1'b0;
    end else begin
      r_tstamp      <= r_tstamp + TS_WIDTH'(1);
      r_win_timer   <= w_win_last ? '0 : r_win_timer + WIN_W'(1);
      r_win_sbe     <= w_win_sbe_nxt;
      r_alert_storm <= (w_win_sbe_nxt == WSB_THRESH);
    end
  end

  // ---------------- record FIFO ----------------
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [REC_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && rec_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push  = w_evt && (!w_full || w_pop);
  assign w_drop  = w_evt && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {w_type, ml_syndrome, r_tstamp};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Fields read as zero while nothing is queued (storage is not reset).
  assign w_head       = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
  assign rec_valid    = !w_empty;
  assign rec_type     = w_head[REC_W-1 -: 2];
  assign rec_syndrome = w_head[TS_WIDTH +: ECC_WIDTH];
  assign rec_tstamp   = w_head[TS_WIDTH-1:0];

  // ---------------- counters and sticky flags ----------------
  logic [CNT_WIDTH-1:0] r_sbe_cnt;
  logic [CNT_WIDTH-1:0] r_par_cnt;
  logic [CNT_WIDTH-1:0] r_dbe_cnt;
  logic                 r_alert_dbe;
  logic                 r_overflow;

  // clr_counts wins over a same-cycle event; the event is still queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbe_cnt   <= '0;
      r_par_cnt   <= '0;
      r_dbe_cnt   <= '0;
      r_alert_dbe <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (clr_counts) begin
      r_sbe_cnt   <= '0;
      r_par_cnt   <= '0;
      r_dbe_cnt   <= '0;
      r_alert_dbe <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_type == TYPE_DATA) r_sbe_cnt <= sat_inc(r_sbe_cnt);
      if (w_type == TYPE_PAR)  r_par_cnt <= sat_inc(r_par_cnt);
      if (w_type == TYPE_DBE) begin
        r_dbe_cnt   <= sat_inc(r_dbe_cnt);
        r_alert_dbe <= 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign sbe_count    = r_sbe_cnt;
  assign par_count    = r_par_cnt;
  assign dbe_count    = r_dbe_cnt;
  assign alert_dbe    = r_alert_dbe;
  assign alert_storm  = r_alert_storm;
  assign rec_overflow = r_overflow;

endmodule

// File: tb/tb_ecc_telemetry_collector.sv
// Testbench for ecc_telemetry_collector. Small parameters (4-bit counters,
// 6-bit timestamp, 16-cycle window, 4-deep FIFO) so saturation, timestamp
// wrap, window rollover and overflow are all reached quickly.

module tb_ecc_telemetry_collector;

  localparam int ECC_W  = 8;
  localparam int CNT_W  = 4;
  localparam int TS_W   = 6;
  localparam int WIN    = 16;
  localparam int THRESH = 4;
  localparam int DEPTH  = 4;
  localparam int REC_W  = 2 + ECC_W + TS_W;
  localparam int OBS_W  = 1 + REC_W + 3 * CNT_W + 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ml_valid = 1'b0;
  logic [ECC_W-1:0] ml_syndrome = '0;
  logic             ml_err_sbe = 1'b0;
  logic             ml_err_dbe = 1'b0;
  logic             ml_err_in_parity = 1'b0;
  logic             clr_counts = 1'b0;
  logic             rec_ready = 1'b0;
  logic             rec_valid;
  logic [1:0]       rec_type;
  logic [ECC_W-1:0] rec_syndrome;
  logic [TS_W-1:0]  rec_tstamp;
  logic [CNT_W-1:0] sbe_count, par_count, dbe_count;
  logic             alert_dbe, alert_storm, rec_overflow;

  always #5 clk = ~clk;

  ecc_telemetry_collector #(
    .ECC_WIDTH(ECC_W), .CNT_WIDTH(CNT_W), .TS_WIDTH(TS_W),
    .WINDOW_CYCLES(WIN), .SBE_THRESH(THRESH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ml_valid(ml_valid), .ml_syndrome(ml_syndrome),
    .ml_err_sbe(ml_err_sbe), .ml_err_dbe(ml_err_dbe),
    .ml_err_in_parity(ml_err_in_parity), .clr_counts(clr_counts),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
    .rec_syndrome(rec_syndrome), .rec_tstamp(rec_tstamp),
    .sbe_count(sbe_count), .par_count(par_count), .dbe_count(dbe_count),
    .alert_dbe(alert_dbe), .alert_storm(alert_storm), .rec_overflow(rec_overflow)
  );

  logic [OBS_W-1:0] obs;
  assign obs = {rec_valid, rec_type, rec_syndrome, rec_tstamp, sbe_count, par_count,
                dbe_count, alert_dbe, alert_storm, rec_overflow};

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- reference model / scoreboard ----------------
  // cyc counts clock edges since reset, so it is the timestamp and the
  // window position of the current cycle (modulo their ranges).
  logic [REC_W-1:0] exp_q[$];
  int cyc = 0;
  int m_sbe = 0, m_par = 0, m_dbe = 0, m_win = 0;
  bit m_adbe = 0, m_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      cyc = 0; m_sbe = 0; m_par = 0; m_dbe = 0; m_win = 0;
      m_adbe = 0; m_ovf = 0;
    end else begin
      logic [1:0] t;
      bit pop, full;
      t = 2'd0;
      if (ml_valid) begin
        if (ml_err_dbe) t = 2'd3;
        else if (ml_err_sbe && ml_err_in_parity) t = 2'd2;
        else if (ml_err_sbe) t = 2'd1;
      end
      full = (exp_q.size() == DEPTH);
      pop  = (exp_q.size() > 0) && rec_ready;
      if (pop) void'(exp_q.pop_front());
      if (t != 0) begin
        if (!full || pop) exp_q.push_back({t, ml_syndrome, TS_W'(cyc % (1 << TS_W))});
      end
      if (clr_counts) begin
        m_sbe = 0; m_par = 0; m_dbe = 0; m_adbe = 0; m_ovf = 0;
      end else begin
        if (t == 1) m_sbe = (m_sbe < CNT_MAX) ? m_sbe + 1 : CNT_MAX;
        if (t == 2) m_par = (m_par < CNT_MAX) ? m_par + 1 : CNT_MAX;
        if (t == 3) begin
          m_dbe = (m_dbe < CNT_MAX) ? m_dbe + 1 : CNT_MAX;
          m_adbe = 1;
        end
        if (t != 0 && full && !pop) m_ovf = 1;
      end
      if ((cyc % WIN) == WIN - 1) m_win = (t == 1 || t == 2) ? 1 : 0;
      else if (t == 1 || t == 2) m_win = (m_win < THRESH) ? m_win + 1 : THRESH;
      cyc++;
    end
  end

  function automatic logic [OBS_W-1:0] model_vec();
    logic [REC_W-1:0] h;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    return {exp_q.size() > 0, h, CNT_W'(m_sbe), CNT_W'(m_par), CNT_W'(m_dbe),
            m_adbe, m_win == THRESH, m_ovf};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input bit v, input bit s, input bit d, input bit p,
                        input logic [ECC_W-1:0] syn);
    ml_valid = v; ml_err_sbe = s; ml_err_dbe = d; ml_err_in_parity = p;
    ml_syndrome = syn;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, '0);
    clr_counts = 1'b0;
    rec_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    if (obs !== '0) begin
      $display("FAIL reset_values: dut=%h required=0", obs); n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean_reads();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 0, 1, 8'($urandom_range(0, 255)));
      @(negedge clk);
      if (obs !== '0) begin
        $display("FAIL clean_read[%0d]: dut=%h required=0", i, obs); n_fail++;
      end
      n_cmp++;
    end
    set_in(0, 0, 0, 0, '0);
  endtask

  task automatic test_data_sbe();
    do_reset();
    for (int k = 0; k < 100 && cyc != 37; k++) @(negedge clk);
    if (cyc != 37) begin
      $display("FAIL data_sbe_wait: tstamp=%0d required=37", cyc); n_fail++;
    end
    n_cmp++;
    set_in(1, 1, 0, 0, 8'h2A);
    @(negedge clk);
    set_in(0, 0, 0, 0, '0);
    if ({rec_valid, rec_type, rec_syndrome, rec_tstamp, sbe_count} !==
        {1'b1, 2'b01, 8'h2A, 6'd37, 4'd1}) begin
      $display("FAIL data_sbe_record: v=%b type=%b syn=%h ts=%0d sbe=%0d required 1/01/2a/37/1",
               rec_valid, rec_type, rec_syndrome, rec_tstamp, sbe_count);
      n_fail++;
    end
    n_cmp++;
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    if (rec_valid !== 1'b0) begin
      $display("FAIL data_sbe_pop: rec_valid=%b required=0", rec_valid); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_in(1, 1, 0, 1, 8'h11);
    @(negedge clk);
    set_in(1, 1, 1, 0, 8'h22);
    @(negedge clk);
    set_in(0, 0, 0, 0, '0);
    if ({rec_valid, rec_type, rec_syndrome, sbe_count, par_count, dbe_count, alert_dbe} !==
        {1'b1, 2'b10, 8'h11, 4'd0, 4'd1, 4'd1, 1'b1}) begin
      $display("FAIL b2b_counts: dut=%b_%b_%h_%0d_%0d_%0d_%b required 1_10_11_0_1_1_1",
               rec_valid, rec_type, rec_syndrome, sbe_count, par_count, dbe_count, alert_dbe);
      n_fail++;
    end
    n_cmp++;
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    if ({sbe_count, par_count, dbe_count, alert_dbe, rec_valid, rec_type} !==
        {12'd0, 1'b0, 1'b1, 2'b10}) begin
      $display("FAIL b2b_clear: cnt=%0d/%0d/%0d adbe=%b v=%b type=%b required 0/0/0 0 1 10",
               sbe_count, par_count, dbe_count, alert_dbe, rec_valid, rec_type);
      n_fail++;
    end
    n_cmp++;
    rec_ready = 1'b1;
    @(negedge clk);
    if ({rec_valid, rec_type, rec_syndrome} !== {1'b1, 2'b11, 8'h22}) begin
      $display("FAIL b2b_second: v=%b type=%b syn=%h required 1/11/22",
               rec_valid, rec_type, rec_syndrome);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    rec_ready = 1'b0;
    if (rec_valid !== 1'b0) begin
      $display("FAIL b2b_empty: rec_valid=%b required=0", rec_valid); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_overflow();
    int t0;
    do_reset();
    repeat (3) @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0, 0, 8'(8'h40 + i));
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, '0);
    if ({rec_overflow, sbe_count, rec_valid} !== {1'b1, 4'd5, 1'b1}) begin
      $display("FAIL overflow_flags: ovf=%b sbe=%0d v=%b required 1/5/1",
               rec_overflow, sbe_count, rec_valid);
      n_fail++;
    end
    n_cmp++;
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ({rec_valid, rec_type, rec_syndrome, rec_tstamp} !==
          {1'b1, 2'b01, 8'(8'h40 + i), TS_W'(t0 + i)}) begin
        $display("FAIL overflow_drain[%0d]: v=%b type=%b syn=%h ts=%0d required 1/01/%h/%0d",
                 i, rec_valid, rec_type, rec_syndrome, rec_tstamp, 8'h40 + i, t0 + i);
        n_fail++;
      end
      n_cmp++;
      @(negedge clk);
    end
    rec_ready = 1'b0;
    if (rec_valid !== 1'b0) begin
      $display("FAIL overflow_empty: rec_valid=%b required=0", rec_valid); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_storm();
    do_reset();
    rec_ready = 1'b1;
    for (int k = 0; k < 42; k++) begin
      bit hit;
      hit = (cyc == 2 || cyc == 5 || cyc == 7 || cyc == 9 ||
             cyc == 29 || cyc == 31 || cyc == 33);
      set_in(hit, hit, 0, 0, 8'(cyc));
      @(negedge clk);
      if (alert_storm !== ((cyc >= 10 && cyc <= 15) ? 1'b1 : 1'b0)) begin
        $display("FAIL storm_alert[cyc %0d]: alert_storm=%b", cyc, alert_storm); n_fail++;
      end
      n_cmp++;
      if (obs !== model_vec()) begin
        $display("FAIL storm_model[cyc %0d]: dut=%h model=%h", cyc, obs, model_vec());
        n_fail++;
      end
      n_cmp++;
    end
    set_in(0, 0, 0, 0, '0);
    rec_ready = 1'b0;
  endtask

  task automatic test_saturation_reset();
    do_reset();
    rec_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, 0, 0, 8'(i));
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, '0);
    if (sbe_count !== 4'd15 || obs !== model_vec()) begin
      $display("FAIL saturation: sbe_count=%0d required=15 dut=%h model=%h",
               sbe_count, obs, model_vec());
      n_fail++;
    end
    n_cmp++;
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, i == 1, i != 1, 0, 8'hC0);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    if (obs !== '0) begin
      $display("FAIL async_reset: dut=%h required=0", obs); n_fail++;
    end
    n_cmp++;
    set_in(0, 0, 0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
             8'($urandom_range(0, 255)));
      rec_ready  = ($urandom_range(0, 3) == 0);
      clr_counts = ($urandom_range(0, 40) == 0);
      @(negedge clk);
      if (obs !== model_vec()) begin
        $display("FAIL random[%0d]: dut=%h model=%h", k, obs, model_vec()); n_fail++;
      end
      n_cmp++;
    end
    set_in(0, 0, 0, 0, '0);
    rec_ready = 1'b0;
    clr_counts = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_reads();
    test_data_sbe();
    test_back_to_back();
    test_overflow();
    test_storm();
    test_saturation_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_telemetry_collector.md
# ecc_telemetry_collector

Consumer of the ECC engine's per-read telemetry (syndrome, SBE, DBE, parity-error flags); it sits between the ECC engine and the PredictRAM ML predictor. Every qualified error is turned into a timestamped error record and queued in a small FIFO that the predictor drains over a valid/ready handshake. The block also keeps saturating lifetime counters, a sticky DBE alarm, and a windowed SBE-storm detector.

## Interface
Parameters:
- ECC_WIDTH, 8, syndrome width (matches the ECC engine)
- CNT_WIDTH, 16, width of lifetime counters
- TS_WIDTH, 16, width of the free-running timestamp
- WINDOW_CYCLES, 1024, storm-detection window length in clocks (≥2)
- SBE_THRESH, 4, SBEs within one window that raise alert_storm (≥1)
- FIFO_DEPTH, 4, record FIFO entries (power of 2, ≥2)

Ports (one clock, `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ml_valid  in  1  telemetry qualifier, driven by the ECC engine's rdata_valid
- ml_syndrome  in  ECC_WIDTH  syndrome of the current read
- ml_err_sbe  in  1  single-bit error (corrected)
- ml_err_dbe  in  1  double-bit error (uncorrectable)
- ml_err_in_parity  in  1  SBE located in check bits
- clr_counts  in  1  sync clear of counters, alert_dbe, rec_overflow
- rec_valid  out  1  FIFO head record valid
- rec_ready  in  1  predictor accepts the head record
- rec_type  out  2  01 data SBE, 10 parity SBE, 11 DBE
- rec_syndrome  out  ECC_WIDTH  syndrome of the head record
- rec_tstamp  out  TS_WIDTH  timestamp of the head record
- sbe_count  out  CNT_WIDTH  lifetime data-SBE count
- par_count  out  CNT_WIDTH  lifetime parity-SBE count
- dbe_count  out  CNT_WIDTH  lifetime DBE count
- alert_dbe  out  1  sticky: any DBE seen since reset/clear
- alert_storm  out  1  SBE storm in the current window
- rec_overflow  out  1  sticky: a record was dropped

## Operation
- Event classification happens only when ml_valid=1. Priority: dbe → type 11; else sbe&in_parity → 10; else sbe → 01; else no event. An in_parity flag without sbe is ignored.
- Each event pushes {type, syndrome, tstamp} into the FIFO. tstamp is a free-running TS_WIDTH counter that wraps modulo 2^TS_WIDTH.
- Counters increment by 1 per event of the matching type and saturate at all-ones. There is no wrap.
- alert_dbe is set on any DBE and holds until clr_counts or reset.
- Storm window:
  - win_timer counts 0..WINDOW_CYCLES-1 and rolls over.
  - win_sbe counts SBEs (data and parity) in the window and saturates at SBE_THRESH.
  - alert_storm=1 when win_sbe==SBE_THRESH.
  - On rollover, win_sbe loads 1 if an SBE arrives in the rollover cycle, otherwise 0. alert_storm follows win_sbe.
- FIFO rules:
  - Pop happens on rec_valid&rec_ready.
  - A push to a full FIFO without a simultaneous pop is dropped and sets rec_overflow.
  - A push to a full FIFO with a simultaneous pop is accepted.
  - A push to an empty FIFO with rec_ready=1 still takes one cycle; there is no combinational bypass.
  - rec_* fields hold stable while rec_valid=1 and rec_ready=0.
- clr_counts takes priority over an event in the same cycle for the counters and alert_dbe; the event is still pushed to the FIFO. clr_counts does not touch the FIFO, the timestamp or the window.

## Timing
- Reset values: rec_valid=0, rec_type=0, rec_syndrome=0, rec_tstamp=0, all counters=0, alert_dbe=0, alert_storm=0, rec_overflow=0. Internal state also resets: tstamp=0, win_timer=0, win_sbe=0, FIFO empty.
- Latency:
  - An event sampled at edge N sets rec_valid (if the FIFO was empty) and updates the counters and alerts after edge N, i.e. they are visible in cycle N+1.
  - rec_tstamp equals the timestamp value present in cycle N.
- Throughput: one event per clock and one pop per clock, sustained.
- Reset asserted mid-operation clears everything immediately (asynchronously). Records in flight are lost.

## Test plan
- Clean reads: 10 cycles with ml_valid=1 and no error flags → rec_valid stays 0, all counters 0, all alerts 0.
- Data SBE: one event with syndrome 0x2A and sbe=1 at tstamp 37 → next cycle rec_valid=1, type 01, syndrome 0x2A, tstamp 37, sbe_count=1. Pulse rec_ready for one cycle → rec_valid=0.
- Parity SBE then DBE back-to-back:
  - Stimulus: parity SBE (sbe=1, in_parity=1), then DBE (dbe=1 and sbe=1).
  - Required: two records, types 10 then 11, in order; par_count=1, dbe_count=1, sbe_count=0; alert_dbe=1.
  - After clr_counts: all counters 0 and alert_dbe=0, while the FIFO keeps its records.
- Overflow: rec_ready=0 and 5 consecutive SBEs with FIFO_DEPTH=4 → 4 records held, rec_overflow=1, sbe_count=5. Drain all 4 and confirm the records are in order with increasing timestamps.
- Storm: WINDOW_CYCLES=16, SBE_THRESH=4; 4 SBEs at window cycles 2, 5, 7, 9 → alert_storm rises after the 4th SBE and clears at the window rollover. 3 SBEs spread across a rollover boundary → alert_storm never asserts.
- Saturation and reset: CNT_WIDTH=4 and 17 SBEs → sbe_count holds at 15. Assert rst_n=0 mid-stream → all outputs go to 0 with no clock edge required.
